// File: rtl/fetch_align_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_align_stage_pkg
// Shared definitions for the RV32IC fetch/align stage:
//   XLEN           - datapath width (32)
//   NOP_INSTR      - canonical NOP (addi x0,x0,0) used for bubbles and reset
//   fetch_state_t  - 2-bit fetch FSM state encoding
//   is_rvc()       - RVC length test: a halfword starts a 16-bit instruction
//                    when its bits[1:0] are not 2'b11
// ---------------------------------------------------------------------------
package fetch_align_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // decide: issue from buffered half or request a word
    ST_WAIT  = 2'd1,  // request outstanding, waiting for imem_rvalid
    ST_HOLD  = 2'd2,  // response captured while IF/ID was stalled
    ST_DROP  = 2'd3   // swallow one stale response after a redirect
  } fetch_state_t;

  function automatic logic is_rvc(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_align_stage_if
// Instruction-memory read port.
//   req    - read request, held until the matching rvalid
//   addr   - word address (bits[1:0] = 0), stable while req is held
//   rvalid - one-cycle response strobe
//   rdata  - response word, valid with rvalid
// Modports: master (fetch stage), slave (instruction memory).
// ---------------------------------------------------------------------------
interface fetch_align_stage_if;
  import fetch_align_stage_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch_halfword_buffer.sv
// ---------------------------------------------------------------------------
// fetch_halfword_buffer
// Holds the upper halfword of the last fetched word and splits/joins
// halfwords into whole instructions. Pure split/join: the FSM, pc and IF/ID
// registers live in the parent.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   flush          - drop the buffered half (redirect)
//   commit         - apply the buffer update for the current assembly
//   pc_half        - pc[1] of the next instruction
//   word/word_valid- fetched word available this cycle
//   need_word      - next instruction needs a memory word
//   word_plus1     - the needed word is pc word + 1 (straddle completion)
//   ready          - a whole instruction is available (instr/compressed/inc4)
//   inc4           - pc advances by 4 (else by 2)
// ---------------------------------------------------------------------------
module fetch_halfword_buffer
  import fetch_align_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            commit,
  input  logic            pc_half,
  input  logic [XLEN-1:0] word,
  input  logic            word_valid,
  output logic            need_word,
  output logic            word_plus1,
  output logic            ready,
  output logic            compressed,
  output logic            inc4,
  output logic [XLEN-1:0] instr
);

  logic [15:0] hbuf_reg, hbuf_next;
  logic        hbuf_valid_reg, hbuf_valid_next;

  always_comb begin
    need_word       = 1'b1;
    word_plus1      = 1'b0;
    ready           = 1'b0;
    compressed      = 1'b0;
    inc4            = 1'b0;
    instr           = NOP_INSTR;
    hbuf_next       = hbuf_reg;
    hbuf_valid_next = hbuf_valid_reg;

    if (pc_half && hbuf_valid_reg) begin
      if (is_rvc(hbuf_reg)) begin
        // Whole 16-bit instruction already buffered: no memory access.
        need_word       = 1'b0;
        ready           = 1'b1;
        compressed      = 1'b1;
        instr           = {16'h0000, hbuf_reg};
        hbuf_valid_next = 1'b0;
      end else begin
        // Straddle: low half buffered, high half is in the next word.
        word_plus1 = 1'b1;
        if (word_valid) begin
          ready           = 1'b1;
          inc4            = 1'b1;
          instr           = {word[15:0], hbuf_reg};
          hbuf_next       = word[31:16];
          hbuf_valid_next = 1'b1;
        end
      end
    end else if (pc_half) begin
      // Odd-halfword pc with nothing buffered (after redirect): use W[31:16].
      if (word_valid) begin
        if (is_rvc(word[31:16])) begin
          ready           = 1'b1;
          compressed      = 1'b1;
          instr           = {16'h0000, word[31:16]};
          hbuf_valid_next = 1'b0;
        end else begin
          // Only the low half of a 32-bit instr: buffer it, pc unchanged,
          // the next pass completes it as a straddle.
          hbuf_next       = word[31:16];
          hbuf_valid_next = 1'b1;
        end
      end
    end else if (word_valid) begin
      if (is_rvc(word[15:0])) begin
        ready           = 1'b1;
        compressed      = 1'b1;
        instr           = {16'h0000, word[15:0]};
        hbuf_next       = word[31:16];
        hbuf_valid_next = 1'b1;
      end else begin
        ready           = 1'b1;
        inc4            = 1'b1;
        instr           = word;
        hbuf_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hbuf_reg       <= 16'h0000;
      hbuf_valid_reg <= 1'b0;
    end else if (flush) begin
      hbuf_valid_reg <= 1'b0;
    end else if (commit) begin
      hbuf_reg       <= hbuf_next;
      hbuf_valid_reg <= hbuf_valid_next;
    end
  end

endmodule

// File: rtl/fetch_align_stage.sv
// ---------------------------------------------------------------------------
// fetch_align_stage
// RV32IC fetch + alignment stage driving the IF/ID register. Fetches aligned
// words, assembles 16/32-bit (possibly word-straddling) instructions, honours
// stall_n (0 = hold) and EX redirects.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating counters
// perf_stall_cycles, perf_bubbles, perf_redirects.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   stall_n                    - 0 holds IF/ID and fetch state
//   redirect_valid/redirect_pc - flush and refetch from redirect_pc (bit0 ignored)
//   imem                       - instruction memory port (master)
//   if_id_valid/instr/pc/compressed - IF/ID register outputs
// ---------------------------------------------------------------------------
module fetch_align_stage
  import fetch_align_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_n,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  fetch_align_stage_if.master imem,
  output logic                if_id_valid,
  output logic [XLEN-1:0]     if_id_instr,
  output logic [XLEN-1:0]     if_id_pc,
  output logic                if_id_compressed
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_bubbles,
  output logic [31:0]         perf_redirects
`endif
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            drop_reg, drop_next;
  logic [XLEN-1:0] hold_word_reg, hold_word_next;
  logic            valid_next, compressed_next;
  logic [XLEN-1:0] instr_next, ifpc_next;

  logic            hb_need_word, hb_word_plus1, hb_ready, hb_compressed, hb_inc4;
  logic [XLEN-1:0] hb_instr, word_sel;
  logic            word_valid, take, load_instr, outstanding;

  // A captured (HOLD) word takes precedence over the live bus.
  assign word_sel   = (state_reg == ST_HOLD) ? hold_word_reg : imem.rdata;
  assign word_valid = !drop_reg &&
                      ((state_reg == ST_WAIT && imem.rvalid) || state_reg == ST_HOLD);
  // take: this cycle's assembly result is consumed (instr issued or half buffered).
  assign take       = stall_n && !redirect_valid &&
                      (word_valid || (state_reg == ST_FETCH && !hb_need_word));
  assign load_instr = take && hb_ready;
  // A response is still owed by memory if we are waiting (or still owe a
  // drop from reset) and it is not arriving this very cycle.
  assign outstanding = (state_reg == ST_WAIT || state_reg == ST_DROP || drop_reg) &&
                       !imem.rvalid;

  // Request is a level held through WAIT; suppressed in reset and on redirect
  // so no request is launched for a pc that is about to be discarded.
  assign imem.req  = rst_n && !redirect_valid &&
                     ((state_reg == ST_FETCH && hb_need_word) || state_reg == ST_WAIT);
  assign imem.addr = {pc_reg[31:2] + {29'd0, hb_word_plus1}, 2'b00};

  fetch_halfword_buffer u_hbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .commit     (take),
    .pc_half    (pc_reg[1]),
    .word       (word_sel),
    .word_valid (word_valid),
    .need_word  (hb_need_word),
    .word_plus1 (hb_word_plus1),
    .ready      (hb_ready),
    .compressed (hb_compressed),
    .inc4       (hb_inc4),
    .instr      (hb_instr)
  );

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    drop_next       = drop_reg && !imem.rvalid;
    hold_word_next  = hold_word_reg;
    valid_next      = if_id_valid;
    instr_next      = if_id_instr;
    ifpc_next       = if_id_pc;
    compressed_next = if_id_compressed;

    if (redirect_valid) begin
      pc_next         = redirect_pc & ~32'h1;
      state_next      = outstanding ? ST_DROP : ST_FETCH;
      drop_next       = 1'b0;  // the single owed response is swallowed by DROP
      valid_next      = 1'b0;
      instr_next      = NOP_INSTR;
      compressed_next = 1'b0;
    end else begin
      case (state_reg)
        ST_FETCH: if (hb_need_word) state_next = ST_WAIT;
        ST_WAIT: begin
          if (word_valid) begin
            state_next     = stall_n ? ST_FETCH : ST_HOLD;
            hold_word_next = imem.rdata;
          end
        end
        ST_HOLD:  if (stall_n) state_next = ST_FETCH;
        ST_DROP:  if (imem.rvalid) state_next = ST_FETCH;
        default:  state_next = ST_FETCH;
      endcase

      if (load_instr) pc_next = pc_reg + (hb_inc4 ? 32'd4 : 32'd2);

      if (stall_n) begin
        if (load_instr) begin
          valid_next      = 1'b1;
          instr_next      = hb_instr;
          ifpc_next       = pc_reg;
          compressed_next = hb_compressed;
        end else begin
          valid_next      = 1'b0;
          instr_next      = NOP_INSTR;
          compressed_next = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ST_FETCH;
      pc_reg           <= RESET_PC;
      drop_reg         <= outstanding;
      hold_word_reg    <= '0;
      if_id_valid      <= 1'b0;
      if_id_instr      <= NOP_INSTR;
      if_id_pc         <= RESET_PC;
      if_id_compressed <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      drop_reg         <= drop_next;
      hold_word_reg    <= hold_word_next;
      if_id_valid      <= valid_next;
      if_id_instr      <= instr_next;
      if_id_pc         <= ifpc_next;
      if_id_compressed <= compressed_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic bubble_load;
  assign bubble_load = redirect_valid || (stall_n && !load_instr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_bubbles      <= '0;
      perf_redirects    <= '0;
    end else begin
      if (!stall_n && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (bubble_load && perf_bubbles != 32'hFFFF_FFFF)
        perf_bubbles <= perf_bubbles + 32'd1;
      if (redirect_valid && perf_redirects != 32'hFFFF_FFFF)
        perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule
